// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 memory-cycle sequencer: one registered BRAM strobe per access, a WAIT_STATES delay, then a one-cycle R pulse.
// The optional user-mode address check is compiled in when LC3_MEM_ACV_CHECK_EN is defined.
module lc3_mem_access_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_MIO_EN,
  input  logic                  i_R_W,
  input  logic [ADDR_WIDTH-1:0] i_MAR,
  input  logic [DATA_WIDTH-1:0] i_MDR,
  input  logic                  i_PSR_15,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_R_Bit,
  output logic                  o_ACV,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    READY  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       rw_r;
  logic       req_viol_s;

`ifdef LC3_MEM_ACV_CHECK_EN
  // User mode may only touch 16'h3000..16'hFDFF; system space and device registers are off limits.
  function automatic logic acv_violation(input logic user_mode, input logic [ADDR_WIDTH-1:0] addr);
    return user_mode && ((addr < ADDR_WIDTH'(16'h3000)) || (addr >= ADDR_WIDTH'(16'hFE00)));
  endfunction

  assign req_viol_s = acv_violation(i_PSR_15, i_MAR);
`else
  logic unused_psr_15;
  assign unused_psr_15 = i_PSR_15;
  assign req_viol_s    = 1'b0;
`endif

  // Access sequencer: every output is loaded here, so all of them are registered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      rw_r        <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_data  <= '0;
      o_R_Bit     <= 1'b0;
      o_ACV       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          o_mem_we <= 1'b0;
          o_mem_re <= 1'b0;
          o_R_Bit  <= 1'b0;
          o_ACV    <= 1'b0;
          if (i_MIO_EN) begin
            o_busy <= 1'b1;
            if (req_viol_s) begin
              // Refused access: skip the RAM entirely and answer at once.
              o_R_Bit <= 1'b1;
              o_ACV   <= 1'b1;
              state_r <= READY;
            end else begin
              o_mem_addr  <= i_MAR;
              o_mem_wdata <= i_MDR;
              rw_r        <= i_R_W;
              o_mem_we    <= i_R_W;
              o_mem_re    <= ~i_R_W;
              state_r     <= ACCESS;
            end
          end else begin
            o_busy  <= 1'b0;
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          o_mem_we <= 1'b0;
          o_mem_re <= 1'b0;
          cnt_r    <= WAIT_LOAD;
          state_r  <= WAIT;
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (!rw_r) begin
              o_mem_data <= i_mem_rdata;
            end else begin
              o_mem_data <= o_mem_data;
            end
            o_R_Bit <= 1'b1;
            state_r <= READY;
          end
        end
        READY: begin
          // Always pass through IDLE so the microsequencer has left its wait state first.
          o_R_Bit <= 1'b0;
          o_ACV   <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          o_mem_we <= 1'b0;
          o_mem_re <= 1'b0;
          o_R_Bit  <= 1'b0;
          o_ACV    <= 1'b0;
          o_busy   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Scoreboard bench for lc3_mem_access_ctrl: two instances (WAIT_STATES 1 and 3) share one stimulus stream.
// Expected strobes and R pulses are queued at drive time and matched by a per-cycle monitor.
module tb_lc3_mem_access_ctrl;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic        acv;
    logic [15:0] data;
  } ready_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        psr_15;

  logic [15:0] rdata [2];
  logic [15:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] mdata [2];
  logic        we    [2];
  logic        re    [2];
  logic        rbit  [2];
  logic        acv   [2];
  logic        busy  [2];

  strobe_t     sq [2][$];
  ready_t      rq [2][$];
  logic [15:0] last_rd [2];
  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  lc3_mem_access_ctrl #(.WAIT_STATES(1)) u_dut_ws1 (
    .i_clk(clk), .i_rst(rst_n), .i_MIO_EN(mio_en), .i_R_W(r_w), .i_MAR(mar), .i_MDR(mdr),
    .i_PSR_15(psr_15), .i_mem_rdata(rdata[0]), .o_mem_addr(addr[0]), .o_mem_wdata(wdata[0]),
    .o_mem_we(we[0]), .o_mem_re(re[0]), .o_mem_data(mdata[0]), .o_R_Bit(rbit[0]),
    .o_ACV(acv[0]), .o_busy(busy[0])
  );

  lc3_mem_access_ctrl #(.WAIT_STATES(3)) u_dut_ws3 (
    .i_clk(clk), .i_rst(rst_n), .i_MIO_EN(mio_en), .i_R_W(r_w), .i_MAR(mar), .i_MDR(mdr),
    .i_PSR_15(psr_15), .i_mem_rdata(rdata[1]), .o_mem_addr(addr[1]), .o_mem_wdata(wdata[1]),
    .o_mem_we(we[1]), .o_mem_re(re[1]), .o_mem_data(mdata[1]), .o_R_Bit(rbit[1]),
    .o_ACV(acv[1]), .o_busy(busy[1])
  );

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1261;
    return a ^ 16'hA5C3;
  endfunction

  // BRAM model: read data appears one cycle after the read strobe and then holds.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (re[i]) rdata[i] <= ram_val(addr[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe and R pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (re[i] || we[i]) begin
        if (sq[i].size() == 0) begin
          check($sformatf("u%0d_extra_strobe", i), 32'd1, 32'd0);
        end else begin
          check($sformatf("u%0d_strobe_cyc", i), 32'(cyc), 32'(sq[i][0].cyc));
          check($sformatf("u%0d_strobe_we", i), 32'(we[i]), 32'(sq[i][0].we));
          check($sformatf("u%0d_strobe_re", i), 32'(re[i]), 32'(!sq[i][0].we));
          check($sformatf("u%0d_strobe_addr", i), 32'(addr[i]), 32'(sq[i][0].addr));
          if (sq[i][0].we) check($sformatf("u%0d_strobe_wdata", i), 32'(wdata[i]), 32'(sq[i][0].wdata));
          sq[i].delete(0);
        end
      end
      if (rbit[i]) begin
        if (rq[i].size() == 0) begin
          check($sformatf("u%0d_extra_r", i), 32'd1, 32'd0);
        end else begin
          check($sformatf("u%0d_r_cyc", i), 32'(cyc), 32'(rq[i][0].cyc));
          check($sformatf("u%0d_r_acv", i), 32'(acv[i]), 32'(rq[i][0].acv));
          check($sformatf("u%0d_r_data", i), 32'(mdata[i]), 32'(rq[i][0].data));
          check($sformatf("u%0d_r_busy", i), 32'(busy[i]), 32'd1);
          rq[i].delete(0);
        end
      end else if (acv[i]) begin
        check($sformatf("u%0d_acv_without_r", i), 32'd1, 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one request for 'hold' cycles, queue what each instance must do, then scramble the inputs.
  task automatic issue(input logic rw, input logic [15:0] a, input logic [15:0] d,
                       input logic psr, input int hold);
    int   c;
    logic viol;
    @(negedge clk);
    mio_en = 1'b1;
    r_w    = rw;
    mar    = a;
    mdr    = d;
    psr_15 = psr;
    c      = cyc;
`ifdef LC3_MEM_ACV_CHECK_EN
    viol = psr && ((a < 16'h3000) || (a >= 16'hFE00));
`else
    viol = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      int ws;
      int sp;
      ws = (i == 0) ? 1 : 3;
      sp = viol ? 2 : 3 + ws;
      for (int t = 0; t < hold; t += sp) begin
        if (viol) begin
          rq[i].push_back('{cyc: c + t + 1, acv: 1'b1, data: last_rd[i]});
        end else begin
          sq[i].push_back('{cyc: c + t + 1, we: rw, addr: a, wdata: d});
          if (!rw) last_rd[i] = ram_val(a);
          rq[i].push_back('{cyc: c + t + 2 + ws, acv: 1'b0, data: last_rd[i]});
        end
      end
    end
    repeat (hold) @(negedge clk);
    mio_en = 1'b0;
    r_w    = ~rw;
    mar    = ~a;
    mdr    = ~d;
  endtask

  logic [15:0] acv_addrs [6];

  initial begin
    acv_addrs = '{16'h0200, 16'h2FFF, 16'h3000, 16'hFDFF, 16'hFE00, 16'hFFFF};
    rst_n  = 1'b0;
    mio_en = 1'b0;
    r_w    = 1'b0;
    mar    = 16'h0000;
    mdr    = 16'h0000;
    psr_15 = 1'b0;
    for (int i = 0; i < 2; i++) last_rd[i] = 16'h0000;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_rst_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d_rst_re", i), 32'(re[i]), 32'd0);
      check($sformatf("u%0d_rst_we", i), 32'(we[i]), 32'd0);
      check($sformatf("u%0d_rst_r", i), 32'(rbit[i]), 32'd0);
      check($sformatf("u%0d_rst_acv", i), 32'(acv[i]), 32'd0);
      check($sformatf("u%0d_rst_mdata", i), 32'(mdata[i]), 32'd0);
      check($sformatf("u%0d_rst_addr", i), 32'(addr[i]), 32'd0);
    end
    rst_n = 1'b1;
    idle(2);

    issue(1'b0, 16'h3000, 16'h0000, 1'b0, 1);
    idle(5);
    issue(1'b1, 16'h4000, 16'hBEEF, 1'b0, 1);
    idle(5);
    issue(1'b0, 16'h3456, 16'h1111, 1'b0, 1);
    idle(5);
    issue(1'b0, 16'h5000, 16'h0000, 1'b0, 5);
    idle(4);
    for (int k = 0; k < 6; k++) begin
      issue(1'b0, acv_addrs[k], 16'h0000, 1'b1, 1);
      idle(5);
    end
    issue(1'b0, 16'h0200, 16'h0000, 1'b0, 1);
    idle(5);

    // Asynchronous reset in the middle of a read's WAIT phase.
    issue(1'b0, 16'h3000, 16'h0000, 1'b0, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sq[i].delete();
      rq[i].delete();
      last_rd[i] = 16'h0000;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_midrst_re", i), 32'(re[i]), 32'd0);
      check($sformatf("u%0d_midrst_we", i), 32'(we[i]), 32'd0);
      check($sformatf("u%0d_midrst_r", i), 32'(rbit[i]), 32'd0);
      check($sformatf("u%0d_midrst_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d_midrst_mdata", i), 32'(mdata[i]), 32'd0);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_post_rst_busy", i), 32'(busy[i]), 32'd0);
    end
    issue(1'b0, 16'h3000, 16'h0000, 1'b0, 1);
    idle(10);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d_pending_strobes", i), 32'(sq[i].size()), 32'd0);
      check($sformatf("u%0d_pending_r", i), 32'(rq[i].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
